adder_acc: RTL and testbench

- Downstream consumer of the two-stage pipelined 8-bit adder.
- Realigns an issue-side valid with the adder's 2-cycle result latency.
- Accumulates a programmed number of 9-bit results ({cout,sum}) into a wide accumulator.
- Presents the frame total on a valid/ready output handshake.
- Sits between the adder and the result-collection logic.

---
 rtl/adder_acc_pkg.sv | 16 +
 rtl/valid_delay.sv | 23 ++
 rtl/adder_acc.sv | 105 ++++++++++
 tb/tb_adder_acc.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_acc_pkg.sv
// adder_acc_pkg: shared state encoding and default widths for the adder
// result accumulator.
package adder_acc_pkg;

   localparam int DEF_DATA_W = 8;   // adder sum width
   localparam int DEF_ACC_W  = 16;  // accumulator width, must exceed DATA_W+1
   localparam int DEF_LAT    = 2;   // adder latency in clocks
   localparam int DEF_CNT_W  = 8;   // frame length field width

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/valid_delay.sv
// valid_delay: LAT-deep 1-bit shift register with async active-low clear.
// Used to walk an issue-side valid alongside a pipelined datapath so it
// lands in the same cycle as the datapath result.
module valid_delay #(
   parameter int LAT = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic [LAT-1:0] vld_pipe;

   // Shift the valid one stage per clock; reset empties the whole line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_pipe <= '0;
      else        vld_pipe <= (vld_pipe << 1) | LAT'(din);
   end

   assign dout = vld_pipe[LAT-1];

endmodule

// File: rtl/adder_acc.sv
// adder_acc: accumulates a programmed number of {cout,sum} results from the
// two-stage adder and hands the frame total downstream on valid/ready.
// Optional build macro ADDER_ACC_SATURATE_EN: clamp the accumulator to
// all-ones on overflow instead of wrapping (acc_ovf is set either way).
module adder_acc
   import adder_acc_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int LAT    = DEF_LAT,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  frame_len,
   input  logic              issue_valid,
   input  logic [DATA_W-1:0] sum,
   input  logic              cout,
   input  logic              out_ready,
   output logic              busy,
   output logic              out_valid,
   output logic [ACC_W-1:0]  acc_out,
   output logic              acc_ovf
);

   localparam int SUM_W = ACC_W + 1;

   state_t             state, state_nxt;
   logic               res_valid;
   logic [CNT_W-1:0]   count;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   acc_nxt;
   logic [SUM_W-1:0]   acc_sum;
   logic               ovf;
   logic               carry;
   logic               frame_open;
   logic               take;
   logic               last;

   // The adder is unreset; its X outputs after reset are masked because the
   // delay line starts empty.
   valid_delay #(.LAT(LAT)) u_vld (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (issue_valid),
      .dout  (res_valid)
   );

   assign frame_open = (state == IDLE) && start && (frame_len != '0);
   assign take       = (state == ACCUM) && res_valid;
   assign last       = take && (count == CNT_W'(1));

   assign acc_sum = {1'b0, acc} + SUM_W'({cout, sum});
   assign carry   = acc_sum[ACC_W];

`ifdef ADDER_ACC_SATURATE_EN
   // Once saturated the accumulator stays pinned for the rest of the frame.
   assign acc_nxt = (ovf || carry) ? '1 : acc_sum[ACC_W-1:0];
`else
   assign acc_nxt = acc_sum[ACC_W-1:0];
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: open on a non-empty start, close on the last result,
   // release on the output handshake.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (frame_open)            state_nxt = ACCUM;
         ACCUM:   if (last)                  state_nxt = DONE;
         DONE:    if (out_ready)             state_nxt = IDLE;
         default:                            state_nxt = IDLE;
      endcase
   end

   // Frame counter, accumulator and sticky overflow; held untouched in DONE
   // so the presented total is stable under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         acc   <= '0;
         ovf   <= 1'b0;
      end else if (frame_open) begin
         count <= frame_len;
         acc   <= '0;
         ovf   <= 1'b0;
      end else if (take) begin
         count <= count - CNT_W'(1);
         acc   <= acc_nxt;
         ovf   <= ovf | carry;
      end
   end

   assign busy      = (state != IDLE);
   assign out_valid = (state == DONE);
   assign acc_out   = acc;
   assign acc_ovf   = ovf;

endmodule

// File: tb/tb_adder_acc.sv
// tb_adder_acc: directed bench for adder_acc with a behavioural two-stage
// adder in front. Expected frame totals go into a queue as frames are issued;
// a monitor pops and compares at each output handshake.
module tb_adder_acc;
   import adder_acc_pkg::*;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 16;
   localparam int LAT    = 2;
   localparam int CNT_W  = 8;

   // 200 * 9'h1FF = 102200 = 0x18F38
`ifdef ADDER_ACC_SATURATE_EN
   localparam logic [15:0] OVF_EXP = 16'hFFFF;
`else
   localparam logic [15:0] OVF_EXP = 16'h8F38;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [CNT_W-1:0]  frame_len = '0;
   logic              issue_valid = 1'b0;
   logic [DATA_W-1:0] sum;
   logic              cout;
   logic              out_ready = 1'b1;
   logic              busy, out_valid, acc_ovf;
   logic [ACC_W-1:0]  acc_out;

   logic [7:0] a = '0, b = '0;
   logic       cin = 1'b0;
   logic [7:0] ra, rb;
   logic       rc;

   typedef struct {
      logic [15:0] acc;
      logic        ovf;
   } exp_t;
   exp_t exp_q[$];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Two-stage adder model, no reset: operand register then result register.
   always @(posedge clk) begin
      ra <= a;
      rb <= b;
      rc <= cin;
      {cout, sum} <= 9'(ra) + 9'(rb) + 9'(rc);
   end

   adder_acc #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LAT(LAT), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .frame_len   (frame_len),
      .issue_valid (issue_valid),
      .sum         (sum),
      .cout        (cout),
      .out_ready   (out_ready),
      .busy        (busy),
      .out_valid   (out_valid),
      .acc_out     (acc_out),
      .acc_ovf     (acc_ovf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic c);
      a = x;
      b = y;
      cin = c;
      issue_valid = 1'b1;
   endtask

   task automatic push_exp(input logic [15:0] acc, input logic ovf);
      exp_t e;
      e.acc = acc;
      e.ovf = ovf;
      exp_q.push_back(e);
   endtask

   task automatic wait_out(input string name, input int max);
      int n;
      n = 0;
      while (!out_valid && n < max) begin
         tick();
         n++;
      end
      check({name, "_out_valid"}, 32'(out_valid), 32'd1);
   endtask

   // Scoreboard monitor: compare the presented total at every handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("acc_out", 32'(acc_out), 32'(e.acc));
               check("acc_ovf", 32'(acc_ovf), 32'(e.ovf));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;

      // Reset state
      #2;
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_acc_out",   32'(acc_out),   32'd0);
      check("rst_acc_ovf",   32'(acc_ovf),   32'd0);
      repeat (2) tick();
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Basic frame: 4 x 9'h1FF = 0x7FC
      push_exp(16'h07FC, 1'b0);
      start = 1'b1; frame_len = 8'd4;
      issue(8'hFF, 8'hFF, 1'b1);
      tick();
      start = 1'b0;
      repeat (3) begin issue(8'hFF, 8'hFF, 1'b1); tick(); end
      issue_valid = 1'b0;
      wait_out("basic", 10);
      repeat (2) tick();
      check("basic_idle_busy", 32'(busy), 32'd0);

      // Latency: single result, out_valid LAT+1 clocks after start
      push_exp(16'd7, 1'b0);
      start = 1'b1; frame_len = 8'd1;
      issue(8'd3, 8'd4, 1'b0);
      tick();
      start = 1'b0; issue_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 10) begin tick(); n++; end
      check("latency", 32'(n), 32'(LAT + 1));
      repeat (2) tick();

      // frame_len=0 start is ignored
      start = 1'b1; frame_len = 8'd0;
      tick();
      start = 1'b0;
      check("len0_busy_a", 32'(busy), 32'd0);
      tick();
      check("len0_busy_b", 32'(busy), 32'd0);

      // A stray result landing in IDLE is discarded, then a gapped frame 2+4+6
      issue(8'd50, 8'd50, 1'b0);
      tick();
      issue_valid = 1'b0;
      tick();
      push_exp(16'd12, 1'b0);
      start = 1'b1; frame_len = 8'd3;
      tick();
      start = 1'b0;
      issue(8'd1, 8'd1, 1'b0); tick(); issue_valid = 1'b0; repeat (2) tick();
      issue(8'd2, 8'd2, 1'b0); tick(); issue_valid = 1'b0; repeat (2) tick();
      issue(8'd3, 8'd3, 1'b0); tick(); issue_valid = 1'b0;
      wait_out("gaps", 10);
      repeat (2) tick();

      // Backpressure: 30 + 11 = 41, held while extra adds and starts arrive
      out_ready = 1'b0;
      push_exp(16'd41, 1'b0);
      start = 1'b1; frame_len = 8'd2;
      issue(8'd10, 8'd20, 1'b0);
      tick();
      start = 1'b0;
      issue(8'd5, 8'd5, 1'b1);
      tick();
      issue_valid = 1'b0;
      wait_out("bp", 10);
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_acc_out",   32'(acc_out),   32'd41);
         check("bp_busy",      32'(busy),      32'd1);
         start = 1'b1; frame_len = 8'd3;
         issue(8'd9, 8'd9, 1'b1);
         tick();
      end
      start = 1'b0; issue_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_release_valid", 32'(out_valid), 32'd0);
      check("bp_release_busy",  32'(busy),      32'd0);
      repeat (3) tick();
      check("bp_stays_idle",    32'(busy),      32'd0);

      // Overflow: 200 x 9'h1FF
      push_exp(OVF_EXP, 1'b1);
      start = 1'b1; frame_len = 8'd200;
      for (int i = 0; i < 200; i++) begin
         issue(8'hFF, 8'hFF, 1'b1);
         tick();
         start = 1'b0;
      end
      issue_valid = 1'b0;
      wait_out("ovf", 10);
      repeat (2) tick();

      // Reset after 2 of 4 results: abandon the frame, then run 15 + 201
      start = 1'b1; frame_len = 8'd4;
      issue(8'd1, 8'd0, 1'b0);
      tick();
      start = 1'b0;
      repeat (3) begin issue(8'd1, 8'd0, 1'b0); tick(); end
      issue_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_busy",      32'(busy),      32'd0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_acc_out",   32'(acc_out),   32'd0);
      check("midrst_acc_ovf",   32'(acc_ovf),   32'd0);
      repeat (2) tick();
      @(negedge clk) rst_n = 1'b1;
      repeat (2) tick();
      check("midrst_no_out", 32'(out_valid), 32'd0);
      push_exp(16'd216, 1'b0);
      start = 1'b1; frame_len = 8'd2;
      issue(8'd7, 8'd8, 1'b0);
      tick();
      start = 1'b0;
      issue(8'd100, 8'd100, 1'b1);
      tick();
      issue_valid = 1'b0;
      wait_out("post_rst", 10);
      repeat (3) tick();

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
